// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: turns a valid/ready request into a SETUP/ACCESS
// transfer, waits on PREADY, and aborts with an error response on timeout.
module apb_master_bridge #(
  parameter int ADDRESS_WIDTH  = 5,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic                     rsp_timeout,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic [ADDRESS_WIDTH-1:0] PADDR,
  output logic                     PWRITE,
  output logic [DATA_WIDTH-1:0]    PWDATA,
  input  logic [DATA_WIDTH-1:0]    PRDATA,
  input  logic                     PREADY,
  input  logic                     PSLVERR
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                   state_r, state_s;
  logic                     psel_r, psel_s;
  logic                     penable_r, penable_s;
  logic [ADDRESS_WIDTH-1:0] paddr_r, paddr_s;
  logic                     pwrite_r, pwrite_s;
  logic [DATA_WIDTH-1:0]    pwdata_r, pwdata_s;
  logic                     rsp_valid_r, rsp_valid_s;
  logic [DATA_WIDTH-1:0]    rsp_rdata_r, rsp_rdata_s;
  logic                     rsp_err_r, rsp_err_s;
  logic                     rsp_timeout_r, rsp_timeout_s;
  logic [CNT_W-1:0]         cnt_r, cnt_s;

  // Next-state and next-output decode; every register holds unless a transition updates it.
  always_comb begin
    state_s       = state_r;
    psel_s        = psel_r;
    penable_s     = penable_r;
    paddr_s       = paddr_r;
    pwrite_s      = pwrite_r;
    pwdata_s      = pwdata_r;
    rsp_valid_s   = rsp_valid_r;
    rsp_rdata_s   = rsp_rdata_r;
    rsp_err_s     = rsp_err_r;
    rsp_timeout_s = rsp_timeout_r;
    cnt_s         = cnt_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          paddr_s   = req_addr;
          pwrite_s  = req_write;
          pwdata_s  = req_wdata;
          psel_s    = 1'b1;
          penable_s = 1'b0;
          state_s   = SETUP;
        end else begin
          state_s   = IDLE;
        end
      end
      SETUP: begin
        penable_s = 1'b1;
        cnt_s     = {CNT_W{1'b0}};
        state_s   = ACCESS;
      end
      ACCESS: begin
        // PREADY takes priority over an expiring timeout on the same edge.
        if (PREADY) begin
          psel_s        = 1'b0;
          penable_s     = 1'b0;
          rsp_rdata_s   = pwrite_r ? {DATA_WIDTH{1'b0}} : PRDATA;
          rsp_err_s     = PSLVERR;
          rsp_timeout_s = 1'b0;
          rsp_valid_s   = 1'b1;
          state_s       = RESP;
        end else if (cnt_r == CNT_LIMIT) begin
          psel_s        = 1'b0;
          penable_s     = 1'b0;
          rsp_rdata_s   = {DATA_WIDTH{1'b0}};
          rsp_err_s     = 1'b1;
          rsp_timeout_s = 1'b1;
          rsp_valid_s   = 1'b1;
          state_s       = RESP;
        end else begin
          cnt_s         = cnt_r + CNT_W'(1'b1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          state_s     = RESP;
        end
      end
      default: begin
        psel_s      = 1'b0;
        penable_s   = 1'b0;
        rsp_valid_s = 1'b0;
        state_s     = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r       <= IDLE;
      psel_r        <= 1'b0;
      penable_r     <= 1'b0;
      paddr_r       <= {ADDRESS_WIDTH{1'b0}};
      pwrite_r      <= 1'b0;
      pwdata_r      <= {DATA_WIDTH{1'b0}};
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
      cnt_r         <= {CNT_W{1'b0}};
    end else begin
      state_r       <= state_s;
      psel_r        <= psel_s;
      penable_r     <= penable_s;
      paddr_r       <= paddr_s;
      pwrite_r      <= pwrite_s;
      pwdata_r      <= pwdata_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_rdata_r   <= rsp_rdata_s;
      rsp_err_r     <= rsp_err_s;
      rsp_timeout_r <= rsp_timeout_s;
      cnt_r         <= cnt_s;
    end
  end

  assign req_ready   = (state_r == IDLE) && PRESETn;
  assign PSEL        = psel_r;
  assign PENABLE     = penable_r;
  assign PADDR       = paddr_r;
  assign PWRITE      = pwrite_r;
  assign PWDATA      = pwdata_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_err     = rsp_err_r;
  assign rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a small zero/variable-wait APB slave
// model; expected values are hand-computed per vector.
module tb_apb_master_bridge;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [4:0] req_addr = 5'd0;
  logic [7:0] req_wdata = 8'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rsp_timeout;
  logic       PSEL;
  logic       PENABLE;
  logic [4:0] PADDR;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY = 1'b0;
  logic       PSLVERR = 1'b0;

  logic [7:0] mem [0:31];
  logic       rd_ovr = 1'b0;
  logic [7:0] rd_val = 8'd0;

  int err_cnt = 0;
  int chk_cnt = 0;

  apb_master_bridge #(.ADDRESS_WIDTH(5), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Slave storage: commits a write on a completing ACCESS edge.
  always @(posedge PCLK) begin
    if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
  end

  assign PRDATA = rd_ovr ? rd_val : mem[PADDR];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one transfer; PREADY goes high on ACCESS cycle index 'waits'.
  task automatic xfer(input logic wr, input logic [4:0] addr, input logic [7:0] wdata,
                      input int waits, input logic slverr,
                      output int psel_n, output int pen_n, output int lat, output logic stable);
    bit done;
    psel_n = 0; pen_n = 0; lat = 0; stable = 1'b1; done = 1'b0;
    @(negedge PCLK);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    PSLVERR = slverr; PREADY = 1'b0;
    @(posedge PCLK);
    for (int cyc = 1; cyc <= 64 && !done; cyc++) begin
      @(negedge PCLK);
      req_valid = 1'b0;
      if (rsp_valid) begin
        done = 1'b1;
        lat = cyc;
      end else begin
        if (PSEL) begin
          psel_n++;
          if (PADDR !== addr || PWRITE !== wr || PWDATA !== wdata) stable = 1'b0;
        end
        if (PSEL && PENABLE) begin
          PREADY = (pen_n == waits);
          pen_n++;
        end else begin
          PREADY = 1'b0;
        end
      end
    end
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    if (!done) check("rsp_bound", 0, 1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ps, pe, lat;
    logic st;

    #12;
    check("rst_req_ready", req_ready, 0);
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // write AA to addr 0, zero wait
    xfer(1'b1, 5'd0, 8'hAA, 0, 1'b0, ps, pe, lat, st);
    check("wr_psel_cycles", ps, 2);
    check("wr_pen_cycles", pe, 1);
    check("wr_latency", lat, 3);
    check("wr_stable", st, 1);
    check("wr_err", rsp_err, 0);
    check("wr_timeout", rsp_timeout, 0);
    check("wr_rdata", rsp_rdata, 0);
    check("wr_psel_low", PSEL, 0);
    consume();
    check("wr_pwdata_hold", PWDATA, 8'hAA);

    // read back addr 0; PWDATA carries req_wdata on reads
    xfer(1'b0, 5'd0, 8'h11, 0, 1'b0, ps, pe, lat, st);
    check("rd_stable", st, 1);
    check("rd_rdata", rsp_rdata, 8'hAA);
    check("rd_err", rsp_err, 0);
    check("rd_pwrite", PWRITE, 0);
    consume();

    // three wait states then 5C
    rd_ovr = 1'b1; rd_val = 8'h5C;
    xfer(1'b0, 5'd7, 8'h22, 3, 1'b0, ps, pe, lat, st);
    check("wait_pen_cycles", pe, 4);
    check("wait_psel_cycles", ps, 5);
    check("wait_stable", st, 1);
    check("wait_rdata", rsp_rdata, 8'h5C);
    consume();
    rd_ovr = 1'b0;

    // slave error on write to addr 31
    xfer(1'b1, 5'd31, 8'h66, 0, 1'b1, ps, pe, lat, st);
    check("slverr_err", rsp_err, 1);
    check("slverr_timeout", rsp_timeout, 0);
    check("slverr_rdata", rsp_rdata, 0);
    check("slverr_paddr", PADDR, 5'd31);
    consume();

    // slave never ready -> timeout after 16 ACCESS cycles
    rd_ovr = 1'b1; rd_val = 8'hFF;
    xfer(1'b0, 5'd2, 8'h00, 1000, 1'b0, ps, pe, lat, st);
    check("to_pen_cycles", pe, 16);
    check("to_err", rsp_err, 1);
    check("to_timeout", rsp_timeout, 1);
    check("to_rdata", rsp_rdata, 0);
    check("to_psel", PSEL, 0);
    check("to_penable", PENABLE, 0);
    consume();
    rd_ovr = 1'b0;

    // write 3C to addr 3, then hold a read response with a competing request pending
    xfer(1'b1, 5'd3, 8'h3C, 0, 1'b0, ps, pe, lat, st);
    check("w3_err", rsp_err, 0);
    consume();
    xfer(1'b0, 5'd0, 8'h00, 0, 1'b0, ps, pe, lat, st);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd9; req_wdata = 8'h99;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_req_ready", req_ready, 0);
      check("hold_rdata", rsp_rdata, 8'hAA);
      check("hold_err", rsp_err, 0);
      check("hold_psel", PSEL, 0);
    end
    req_valid = 1'b0;
    consume();
    check("hold_paddr_kept", PADDR, 5'd0);

    // reset in the middle of ACCESS
    @(negedge PCLK);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd3; req_wdata = 8'h77;
    PREADY = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    req_valid = 1'b0;
    @(negedge PCLK);
    check("pre_rst_access", PSEL && PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    check("mid_rst_psel", PSEL, 0);
    check("mid_rst_penable", PENABLE, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_req_ready", req_ready, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_psel", PSEL, 0);

    xfer(1'b0, 5'd3, 8'h00, 0, 1'b0, ps, pe, lat, st);
    check("post_rst_rdata", rsp_rdata, 8'h3C);
    check("post_rst_err", rsp_err, 0);
    check("post_rst_latency", lat, 3);
    consume();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB master that converts a valid/ready request/response interface into APB SETUP/ACCESS transfers.
- Sits directly upstream of the APB slaves in this codebase, noWait_APB_slave included.
- Drives PSEL, PENABLE, PADDR, PWRITE and PWDATA. Returns PRDATA and PSLVERR to the requester.
- Supports PREADY wait states and aborts with a timeout if the slave never responds.

Parameters:
- ADDRESS_WIDTH, 5, width of PADDR and req_addr
- DATA_WIDTH, 8, width of PWDATA, PRDATA, req_wdata and rsp_rdata
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles before abort; must be ≥2

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESETn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  bridge accepts request
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDRESS_WIDTH  transfer address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_err  out  1  PSLVERR seen, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PADDR  out  ADDRESS_WIDTH  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

Behaviour:
- Reset (PRESETn low, asynchronous):
  - state=IDLE.
  - PSEL, PENABLE, PADDR, PWRITE, PWDATA all 0.
  - rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0.
  - Timeout counter=0.
  - req_ready=0 while PRESETn is low.
- All outputs are registered except req_ready, which equals (state==IDLE) && PRESETn.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: on an edge with req_valid && req_ready:
  - Capture req_addr/req_write/req_wdata into PADDR/PWRITE/PWDATA.
  - Set PSEL=1, PENABLE=0, go to SETUP.
  - PWDATA takes req_wdata even on reads.
- SETUP: exactly one cycle. Next edge sets PENABLE=1, clears the counter, goes to ACCESS.
- ACCESS, on each edge:
  - If PREADY=1: PSEL=0, PENABLE=0. rsp_rdata=PRDATA for a read, 0 for a write. rsp_err=PSLVERR, rsp_timeout=0, rsp_valid=1. Go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: abort. PSEL=0, PENABLE=0, rsp_rdata=0, rsp_err=1, rsp_timeout=1, rsp_valid=1. Go to RESP.
  - Else: counter+1, all APB outputs held stable.
  - PREADY=1 on the same edge as the timeout limit completes normally (PREADY wins).
- PSLVERR is sampled only when PSEL && PENABLE && PREADY.
- RESP:
  - rsp_* held stable while rsp_ready=0.
  - On an edge with rsp_ready=1: rsp_valid=0, go to IDLE.
  - rsp_rdata/rsp_err/rsp_timeout keep their values until the next response.
- PADDR, PWRITE and PWDATA hold their last values after a transfer ends.
- Latency with a zero-wait slave and rsp_ready=1:
  - Accept edge T.
  - PSEL high from T. PENABLE high from T+1.
  - rsp_valid high from T+2, response consumed at T+3.
  - Next accept edge no earlier than T+4.
- Throughput: one outstanding transfer only. No new request is accepted before the response handshake.
- Reset mid-transfer: PSEL/PENABLE drop immediately (asynchronously). Any pending response is discarded and no response is issued.

Test Plan:
- Write 8'hAA to addr 0 through noWait_APB_slave, rsp_ready=1 -> PSEL 1 for 2 cycles, PENABLE 1 for 1 cycle, PWDATA=8'hAA; rsp_valid one cycle later with rsp_err=0, rsp_timeout=0.
- Read addr 0 after that write -> rsp_rdata=8'hAA, rsp_err=0; PWRITE=0 during the transfer.
- Slave holds PREADY=0 for 3 ACCESS cycles, then PREADY=1 with PRDATA=8'h5C -> PSEL/PENABLE/PADDR stable for 4 ACCESS cycles; rsp_rdata=8'h5C.
- PREADY=1 with PSLVERR=1 on a write to addr 5'd31 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- PREADY tied 0, TIMEOUT_CYCLES=16 -> PENABLE high exactly 16 cycles, then rsp_valid=1, rsp_err=1, rsp_timeout=1; PSEL=0.
- rsp_ready held 0 for 5 cycles, then PRESETn pulsed low mid-ACCESS on the next transfer:
  - During the hold, rsp_* stay stable and req_ready=0.
  - On reset, PSEL=PENABLE=rsp_valid=0 at once.
  - After reset, a read of addr 3 completes normally.
